// File: rtl/ram_dp_sync.sv
// ram_dp_sync: simple dual-port synchronous RAM with byte-lane writes,
// a 1- or 2-cycle registered read path, selectable same-address collision
// behaviour and a sequential zero-fill engine (after reset and on clr).

module ram_dp_sync #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RW_MODE    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    input  logic                      clr,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rvalid,
    output logic                      busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clrCnt;

    logic                  r_s1Valid;
    logic [DATA_WIDTH-1:0] r_s1Data;

    logic                  w_idle;
    logic                  w_userWe;
    logic                  w_userRe;
    logic                  w_clearWe;
    logic [DATA_WIDTH-1:0] w_mergedWord;
    logic [DATA_WIDTH-1:0] w_readData;

    // User requests only count while no fill is running; the fill write is
    // gated by reset_n so that a held reset never touches the array.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_userWe  = w_idle & we;
    assign w_userRe  = w_idle & re;
    assign w_clearWe = (r_state == ST_CLEAR) & reset_n;
    assign busy      = (r_state == ST_CLEAR);

    // Word at waddr after this cycle's write, used for write-first collisions.
    always_comb begin
        w_mergedWord = r_mem[waddr];
        for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) begin
                w_mergedWord[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Read data selection: write-first mode forwards the merged word on a hit.
    always_comb begin
        w_readData = r_mem[raddr];
        if ((RW_MODE != 0) && we && (waddr == raddr)) begin
            w_readData = w_mergedWord;
        end
    end

    // Array update: fill writes zero to the counter's word, otherwise lane writes.
    always_ff @(posedge clk) begin
        if (w_clearWe) begin
            r_mem[r_clrCnt] <= '0;
        end else if (w_userWe) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Controller: IDLE accepts requests and clr; CLEAR walks every word once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RESET;
            r_clrCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        r_state  <= ST_CLEAR;
                        r_clrCnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_clrCnt <= r_clrCnt + 1'b1;
                    if (r_clrCnt == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // First read stage: captures the addressed word when a read is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
        end else begin
            r_s1Valid <= w_userRe;
            if (w_userRe) begin
                r_s1Data <= w_readData;
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : gLat1
            assign rdata  = r_s1Data;
            assign rvalid = r_s1Valid;
        end else begin : gLat2
            logic                  r_s2Valid;
            logic [DATA_WIDTH-1:0] r_s2Data;

            // Second read stage: one extra register, data held between results.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s2Valid <= 1'b0;
                    r_s2Data  <= '0;
                end else begin
                    r_s2Valid <= r_s1Valid;
                    if (r_s1Valid) begin
                        r_s2Data <= r_s1Data;
                    end
                end
            end

            assign rdata  = r_s2Data;
            assign rvalid = r_s2Valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_sync.sv
// tb_ram_dp_sync: drives four ram_dp_sync instances (every RD_LATENCY x
// RW_MODE pairing) with shared stimulus and compares each against a
// behavioural model built from an array and per-instance result queues.

module tb_ram_dp_sync;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NB = 2;
    localparam int NI = 4;
    localparam int NWORDS = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic we = 1'b0;
    logic re = 1'b0;
    logic clr = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NB-1:0] wstrb = '0;

    logic [NI-1:0][DW-1:0] rdataV;
    logic [NI-1:0]         rvalidV;
    logic [NI-1:0]         busyV;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : gDut
            ram_dp_sync #(
                .ADDR_WIDTH(AW),
                .DATA_WIDTH(DW),
                .RD_LATENCY((gi % 2) + 1),
                .RW_MODE(gi / 2),
                .INIT_CLEAR(1)
            ) uDut (
                .clk(clk),
                .reset_n(reset_n),
                .we(we),
                .waddr(waddr),
                .wdata(wdata),
                .wstrb(wstrb),
                .re(re),
                .raddr(raddr),
                .clr(clr),
                .rdata(rdataV[gi]),
                .rvalid(rvalidV[gi]),
                .busy(busyV[gi])
            );
        end
    endgenerate

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } expRead_t;

    logic [DW-1:0] mdlMem [NWORDS];
    bit            mdlBusy;
    int            mdlClrIdx;
    int            cycleNum;
    expRead_t      expQ [NI][$];
    logic [DW-1:0] lastData [NI];

    int nCompared = 0;
    int nMismatched = 0;

    function automatic int latOf(input int k);
        return (k % 2) + 1;
    endfunction

    function automatic int modeOf(input int k);
        return k / 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Model of one rising edge, using the inputs currently driven.
    task automatic modelEdge;
        logic [DW-1:0] oldWord;
        logic [DW-1:0] merged;
        logic [DW-1:0] v;
        cycleNum++;
        if (mdlBusy) begin
            mdlMem[mdlClrIdx] = '0;
            mdlClrIdx++;
            if (mdlClrIdx == NWORDS) mdlBusy = 1'b0;
        end else begin
            oldWord = mdlMem[raddr];
            merged  = mdlMem[waddr];
            for (int b = 0; b < NB; b++)
                if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
            if (re) begin
                for (int k = 0; k < NI; k++) begin
                    v = (modeOf(k) == 1 && we && waddr == raddr) ? merged : oldWord;
                    expQ[k].push_back('{due: cycleNum + latOf(k) - 1, data: v});
                end
            end
            if (we) mdlMem[waddr] = merged;
            if (clr) begin
                mdlBusy   = 1'b1;
                mdlClrIdx = 0;
            end
        end
    endtask

    task automatic checkCycle;
        logic          expValid;
        logic [DW-1:0] expData;
        for (int k = 0; k < NI; k++) begin
            if (expQ[k].size() > 0 && expQ[k][0].due == cycleNum) begin
                expValid = 1'b1;
                expData  = expQ[k][0].data;
                lastData[k] = expData;
                void'(expQ[k].pop_front());
            end else begin
                expValid = 1'b0;
                expData  = lastData[k];
            end
            checkOutput($sformatf("rvalid[%0d]@%0d", k, cycleNum), {31'h0, rvalidV[k]}, {31'h0, expValid});
            checkOutput($sformatf("rdata[%0d]@%0d", k, cycleNum), {16'h0, rdataV[k]}, {16'h0, expData});
            checkOutput($sformatf("busy[%0d]@%0d", k, cycleNum), {31'h0, busyV[k]}, {31'h0, mdlBusy});
        end
    endtask

    // Drive one cycle of inputs, advance the model and check after the edge.
    task automatic applyStimulus(input logic iWe, input logic [AW-1:0] iWaddr,
                                 input logic [DW-1:0] iWdata, input logic [NB-1:0] iWstrb,
                                 input logic iRe, input logic [AW-1:0] iRaddr, input logic iClr);
        we = iWe; waddr = iWaddr; wdata = iWdata; wstrb = iWstrb;
        re = iRe; raddr = iRaddr; clr = iClr;
        modelEdge();
        @(posedge clk);
        #1;
        checkCycle();
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic readAll;
        for (int i = 0; i < NWORDS; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
        idleCycles(2);
    endtask

    // Asynchronous reset pulse spanning one clock edge; outputs must clear at once.
    task automatic doReset(input string tag);
        we = 1'b0; re = 1'b0; clr = 1'b0;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s_rvalid[%0d]", tag, k), {31'h0, rvalidV[k]}, 32'h0);
            checkOutput($sformatf("%s_rdata[%0d]", tag, k), {16'h0, rdataV[k]}, 32'h0);
            checkOutput($sformatf("%s_busy[%0d]", tag, k), {31'h0, busyV[k]}, 32'h1);
            expQ[k].delete();
            lastData[k] = '0;
        end
        mdlBusy   = 1'b1;
        mdlClrIdx = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s_held_rvalid[%0d]", tag, k), {31'h0, rvalidV[k]}, 32'h0);
            checkOutput($sformatf("%s_held_busy[%0d]", tag, k), {31'h0, busyV[k]}, 32'h1);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic randomCycle(input bit allowClr);
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        ra = AW'($urandom_range(0, NWORDS - 1));
        wa = ($urandom % 3 == 0) ? ra : AW'($urandom_range(0, NWORDS - 1));
        applyStimulus(1'($urandom % 2), wa, DW'($urandom), NB'($urandom),
                      1'($urandom % 2), ra,
                      allowClr ? 1'($urandom % 40 == 0) : 1'b0);
    endtask

    initial begin
        cycleNum = 0;
        mdlBusy = 1'b1;
        mdlClrIdx = 0;
        for (int i = 0; i < NWORDS; i++) mdlMem[i] = '0;
        for (int k = 0; k < NI; k++) lastData[k] = '0;

        #1;
        doReset("init_reset");

        // Automatic fill after reset, then every word must read zero.
        idleCycles(16);
        readAll();

        // Partial byte-lane write.
        applyStimulus(1'b1, 4'd5, 16'hABCD, 2'b11, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        idleCycles(2);
        for (int k = 0; k < NI; k++)
            checkOutput($sformatf("partial_wr[%0d]", k), {16'h0, rdataV[k]}, 32'h0000AB34);

        // Same-address collision.
        applyStimulus(1'b1, 4'd3, 16'h1111, 2'b11, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 4'd3, 16'h5A5A, 2'b11, 1'b1, 4'd3, 1'b0);
        idleCycles(2);
        for (int k = 0; k < NI; k++)
            checkOutput($sformatf("collision[%0d]", k), {16'h0, rdataV[k]},
                        (modeOf(k) == 1) ? 32'h00005A5A : 32'h00001111);

        // Random fill of the array, then a back-to-back read sweep.
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b1, AW'($urandom_range(0, NWORDS - 1)), DW'($urandom), NB'($urandom), 1'b0, '0, 1'b0);
        readAll();

        // clr together with a read, then ignored requests while busy.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b1);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, AW'($urandom_range(0, NWORDS - 1)), 16'hFFFF, 2'b11,
                          1'b1, AW'($urandom_range(0, NWORDS - 1)), 1'($urandom % 2));
        readAll();

        // Mixed random traffic including occasional clr pulses.
        for (int i = 0; i < 400; i++) randomCycle(1'b1);
        idleCycles(20);
        readAll();

        // Reset with a read still in flight.
        applyStimulus(1'b1, 4'd7, 16'hC0DE, 2'b11, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
        doReset("inflight_reset");
        idleCycles(16);
        readAll();

        // Reset in the middle of a fill with clr_cnt at 7.
        applyStimulus(1'b1, 4'd2, 16'hBEEF, 2'b11, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        idleCycles(7);
        doReset("midfill_reset");
        idleCycles(16);
        readAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
RAM_DP_SYNC -- requirements
Module: ram_dp_sync

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- RW_MODE, 0, same-address collision behaviour; 0 = read-first, 1 = write-first.
- INIT_CLEAR, 1, when 1 the array is zero-filled automatically after reset.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- we, in, 1, write request.
- waddr, in, ADDR_WIDTH, write address.
- wdata, in, DATA_WIDTH, write data.
- wstrb, in, NB, byte-lane write enables; bit i covers wdata[8i+7:8i].
- re, in, 1, read request.
- raddr, in, ADDR_WIDTH, read address.
- clr, in, 1, single-cycle pulse that starts a zero-fill of the whole array.
- rdata, out, DATA_WIDTH, registered read data.
- rvalid, out, 1, one-cycle strobe marking new rdata.
- busy, out, 1, high while a zero-fill runs; user requests are ignored while it is high.

Function
REQ-003 The block SHALL have a two-state controller, IDLE and CLEAR, plus an ADDR_WIDTH-bit clear counter clr_cnt.
REQ-004 In IDLE, with we=1 at a rising edge, byte lane i of word waddr SHALL be written if and only if wstrb[i]=1; other lanes keep their values.
REQ-005 In IDLE, with re=1 at edge N, word raddr SHALL be captured at edge N.
- RD_LATENCY=1: rdata is updated and rvalid=1 in the cycle after edge N.
- RD_LATENCY=2: the result passes through one more register; rdata is updated and rvalid=1 in the cycle after edge N+1.
REQ-006 rvalid SHALL be high for exactly one cycle per accepted read; with back-to-back reads it SHALL stay high continuously, giving one result per cycle in request order.
REQ-007 When no read result is being presented, rdata SHALL hold its last value and rvalid SHALL be 0.
REQ-008 If we=1, re=1 and waddr=raddr in the same cycle, the read SHALL return:
- RW_MODE=0: the pre-write word.
- RW_MODE=1: the pre-write word with the lanes enabled by wstrb replaced by wdata.
REQ-009 Simultaneous reads and writes to different addresses SHALL be independent of each other.
REQ-010 clr=1 sampled in IDLE at edge N SHALL move the controller to CLEAR after edge N, with clr_cnt=0; the we/re of that same cycle SHALL still be accepted.
REQ-011 In CLEAR, each edge SHALL write all-zeros to word clr_cnt and increment clr_cnt. After the edge that writes word DEPTH-1, the controller SHALL return to IDLE, so busy is high for exactly DEPTH cycles.
REQ-012 busy SHALL be 1 exactly when the controller is in CLEAR. While busy=1:
- we and re SHALL be ignored; no write occurs and no read is accepted.
- clr SHALL be ignored; a running fill does not restart.
REQ-013 Reads accepted before CLEAR was entered SHALL complete normally; their rdata/rvalid may appear while busy=1.
REQ-014 Addresses SHALL be used unmodified; there is no wrap or bounds logic, because every ADDR_WIDTH value is in range.

Reset
REQ-015 While reset_n=0, regardless of clk:
- rvalid=0, rdata=0, and the read pipeline is cleared.
- clr_cnt=0.
- the controller is in CLEAR if INIT_CLEAR=1, else in IDLE.
- busy equals INIT_CLEAR.
REQ-016 Reset SHALL NOT clear the array directly; zero content is guaranteed only through INIT_CLEAR or clr.
REQ-017 A reset asserted during a fill or with reads in flight SHALL abort both immediately. In-flight reads produce no rvalid.

Verification
REQ-018 The bench SHALL use ADDR_WIDTH=4, DATA_WIDTH=16 and cover all RD_LATENCY and RW_MODE combinations. Directed scenarios:
- Reset release with INIT_CLEAR=1 -> busy=1 for 16 cycles; then reading addresses 0..15 gives rdata=0x0000 each, with rvalid 1 or 2 cycles after each re.
- Write 0xABCD to address 5 with wstrb=2'b11, then write 0x1234 with wstrb=2'b01, then read address 5 -> rdata=0xAB34.
- Same-cycle write of 0x5A5A (wstrb=2'b11) and read of address 3, which holds 0x1111 -> rdata=0x1111 with RW_MODE=0, 0x5A5A with RW_MODE=1.
- Reads of addresses 0..15 on consecutive cycles -> rvalid stays high for 16 consecutive cycles and the data is in address order.
- clr pulse, then we/re attempts during busy -> no write occurs, no rvalid, busy drops after 16 cycles, and every word reads 0.
- reset_n pulsed low mid-fill with clr_cnt=7 -> rvalid=0 and rdata=0 at once; the fill restarts from address 0 if INIT_CLEAR=1.
